// File: rtl/cfg_afu_reset_seq.sv
// ---------------------------------------------------------------------------
// cfg_afu_reset_seq
//
// Sequences the OpenCAPI function-1 reset and the AFU control-00 "Reset AFU"
// request toward the AFU. A request fences the AFU and waits for it to drain.
// It then holds the AFU in reset for the advertised duration, releases reset,
// and keeps the fence up for a settle period. Last, it clears the
// reset-in-progress status bits that config reads return.
//
// Ports:
//   clock                    single clock domain
//   reset_n                  asynchronous, active-low reset
//   ofunc_func_reset_pulse   1-cycle pulse: function reset requested
//   octrl_reset_afu_pulse    1-cycle pulse: "Reset AFU" written to 1
//   octrl_enable_afu         config-space Enable AFU bit
//   ro_ofunc_reset_duration  function reset duration, in ticks
//   ro_octrl_reset_duration  AFU reset duration, in ticks
//   afu_quiesced             AFU reports no outstanding commands
//   err_clear                clears fence_timeout_err
//   afu_reset_n              active-low reset to the AFU
//   afu_fence                blocks new AFU commands/responses
//   afu_enable               Enable AFU, qualified by the sequencer being idle
//   ofunc_reset_in_progress  status bit for the ofunc DVSEC
//   octrl_reset_in_progress  status bit for the octrl DVSEC
//   fence_timeout_err        sticky flag: AFU failed to quiesce in time
// ---------------------------------------------------------------------------
module cfg_afu_reset_seq #(
  parameter int unsigned TICK_CYCLES   = 256,
  parameter int unsigned FENCE_TIMEOUT = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ofunc_func_reset_pulse,
  input  logic       octrl_reset_afu_pulse,
  input  logic       octrl_enable_afu,
  input  logic [7:0] ro_ofunc_reset_duration,
  input  logic [7:0] ro_octrl_reset_duration,
  input  logic       afu_quiesced,
  input  logic       err_clear,
  output logic       afu_reset_n,
  output logic       afu_fence,
  output logic       afu_enable,
  output logic       ofunc_reset_in_progress,
  output logic       octrl_reset_in_progress,
  output logic       fence_timeout_err
);

  // The fence counter only has to reach FENCE_TIMEOUT-1.
  localparam int unsigned FW = (FENCE_TIMEOUT > 1) ? $clog2(FENCE_TIMEOUT) : 1;

  localparam logic [15:0]   TICK_LAST   = 16'(TICK_CYCLES - 1);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] FENCE_LAST  = FW'(FENCE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FENCE   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RESET   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]    unit_cnt_q, unit_cnt_d;
  logic [FW-1:0] fence_cnt_q, fence_cnt_d;
  logic [7:0]    settle_cnt_q, settle_cnt_d;

  logic afu_reset_n_q, afu_reset_n_d;
  logic afu_fence_q, afu_fence_d;
  logic afu_enable_q, afu_enable_d;
  logic ofunc_busy_q, ofunc_busy_d;
  logic octrl_busy_q, octrl_busy_d;
  logic fence_err_q, fence_err_d;

  logic       tick_last_s;
  logic       fence_timeout_s;
  logic       any_pulse_s;
  logic [7:0] dur_sel_s;

  assign tick_last_s = (tick_cnt_q == TICK_LAST);
  assign any_pulse_s = ofunc_func_reset_pulse | octrl_reset_afu_pulse;

  // Next-state logic. A function reset pulse in LOAD/RESET/RELEASE/DONE
  // restarts from LOAD so the full function duration is always applied.
  always_comb begin
    state_d         = state_q;
    fence_timeout_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pulse_s) state_d = ST_FENCE;
        else             state_d = ST_IDLE;
      end
      ST_FENCE: begin
        if (afu_quiesced) begin
          state_d = ST_LOAD;
        end else if (fence_cnt_q == FENCE_LAST) begin
          state_d         = ST_LOAD;
          fence_timeout_s = 1'b1;
        end else begin
          state_d = ST_FENCE;
        end
      end
      ST_LOAD: begin
        if (ofunc_func_reset_pulse) state_d = ST_LOAD;
        else                        state_d = ST_RESET;
      end
      ST_RESET: begin
        if (ofunc_func_reset_pulse)                   state_d = ST_LOAD;
        else if (tick_last_s && unit_cnt_q <= 8'd1)   state_d = ST_RELEASE;
        else                                          state_d = ST_RESET;
      end
      ST_RELEASE: begin
        if (ofunc_func_reset_pulse)          state_d = ST_LOAD;
        else if (settle_cnt_q == SETTLE_LAST) state_d = ST_DONE;
        else                                  state_d = ST_RELEASE;
      end
      ST_DONE: begin
        // Status already cleared on entry; a new AFU request here is a
        // fresh request, so it is fenced again instead of being dropped.
        if (ofunc_func_reset_pulse)     state_d = ST_LOAD;
        else if (octrl_reset_afu_pulse) state_d = ST_FENCE;
        else                            state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Counters: fence/settle/tick count while staying in their state and
  // restart from zero on entry; the unit counter is loaded only in LOAD.
  always_comb begin
    fence_cnt_d  = {FW{1'b0}};
    settle_cnt_d = 8'd0;
    tick_cnt_d   = 16'd0;
    unit_cnt_d   = unit_cnt_q;

    if (ofunc_busy_q) dur_sel_s = ro_ofunc_reset_duration;
    else              dur_sel_s = ro_octrl_reset_duration;

    if (state_q == ST_FENCE && state_d == ST_FENCE) fence_cnt_d = fence_cnt_q + FW'(1);
    else                                            fence_cnt_d = {FW{1'b0}};

    if (state_q == ST_RELEASE && state_d == ST_RELEASE) settle_cnt_d = settle_cnt_q + 8'd1;
    else                                                settle_cnt_d = 8'd0;

    if (state_q == ST_RESET && state_d == ST_RESET) begin
      if (tick_last_s) tick_cnt_d = 16'd0;
      else             tick_cnt_d = tick_cnt_q + 16'd1;
    end else begin
      tick_cnt_d = 16'd0;
    end

    // A zero duration still gives one tick of reset.
    if (state_q == ST_LOAD) begin
      if (dur_sel_s == 8'd0) unit_cnt_d = 8'd1;
      else                   unit_cnt_d = dur_sel_s;
    end else if (state_q == ST_RESET && state_d == ST_RESET && tick_last_s) begin
      unit_cnt_d = unit_cnt_q - 8'd1;
    end else begin
      unit_cnt_d = unit_cnt_q;
    end
  end

  // Output and status next values, derived from the next state so each
  // registered output lines up with the state register.
  always_comb begin
    afu_reset_n_d = ~((state_d == ST_LOAD) || (state_d == ST_RESET));
    afu_fence_d   = (state_d != ST_IDLE);
    afu_enable_d  = octrl_enable_afu & (state_d == ST_IDLE);

    if (state_d == ST_DONE) begin
      ofunc_busy_d = 1'b0;
      octrl_busy_d = 1'b0;
    end else begin
      ofunc_busy_d = ofunc_busy_q | ofunc_func_reset_pulse;
      octrl_busy_d = octrl_busy_q | octrl_reset_afu_pulse;
    end

    // Set has priority over a simultaneous clear.
    if (fence_timeout_s) fence_err_d = 1'b1;
    else if (err_clear)  fence_err_d = 1'b0;
    else                 fence_err_d = fence_err_q;
  end

  // State, counter and output registers. Reset lands in LOAD so that a
  // function reset runs automatically after power-up.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_LOAD;
      tick_cnt_q    <= 16'd0;
      unit_cnt_q    <= 8'd0;
      fence_cnt_q   <= {FW{1'b0}};
      settle_cnt_q  <= 8'd0;
      afu_reset_n_q <= 1'b0;
      afu_fence_q   <= 1'b1;
      afu_enable_q  <= 1'b0;
      ofunc_busy_q  <= 1'b1;
      octrl_busy_q  <= 1'b0;
      fence_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      unit_cnt_q    <= unit_cnt_d;
      fence_cnt_q   <= fence_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      afu_reset_n_q <= afu_reset_n_d;
      afu_fence_q   <= afu_fence_d;
      afu_enable_q  <= afu_enable_d;
      ofunc_busy_q  <= ofunc_busy_d;
      octrl_busy_q  <= octrl_busy_d;
      fence_err_q   <= fence_err_d;
    end
  end

  assign afu_reset_n             = afu_reset_n_q;
  assign afu_fence               = afu_fence_q;
  assign afu_enable              = afu_enable_q;
  assign ofunc_reset_in_progress = ofunc_busy_q;
  assign octrl_reset_in_progress = octrl_busy_q;
  assign fence_timeout_err       = fence_err_q;

endmodule

// File: tb/tb_cfg_afu_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_cfg_afu_reset_seq
//
// Directed bench for cfg_afu_reset_seq with TICK_CYCLES=4, SETTLE_CYCLES=4,
// FENCE_TIMEOUT=8. Inputs change and outputs are sampled 1 time unit after
// each rising clock edge.
// ---------------------------------------------------------------------------
module tb_cfg_afu_reset_seq;

  logic       clock;
  logic       reset_n;
  logic       ofunc_func_reset_pulse;
  logic       octrl_reset_afu_pulse;
  logic       octrl_enable_afu;
  logic [7:0] ro_ofunc_reset_duration;
  logic [7:0] ro_octrl_reset_duration;
  logic       afu_quiesced;
  logic       err_clear;
  logic       afu_reset_n;
  logic       afu_fence;
  logic       afu_enable;
  logic       ofunc_reset_in_progress;
  logic       octrl_reset_in_progress;
  logic       fence_timeout_err;

  int err_cnt;
  int chk_cnt;
  int low_n;
  int bad_n;

  cfg_afu_reset_seq #(
    .TICK_CYCLES  (4),
    .FENCE_TIMEOUT(8),
    .SETTLE_CYCLES(4)
  ) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .ofunc_func_reset_pulse (ofunc_func_reset_pulse),
    .octrl_reset_afu_pulse  (octrl_reset_afu_pulse),
    .octrl_enable_afu       (octrl_enable_afu),
    .ro_ofunc_reset_duration(ro_ofunc_reset_duration),
    .ro_octrl_reset_duration(ro_octrl_reset_duration),
    .afu_quiesced           (afu_quiesced),
    .err_clear              (err_clear),
    .afu_reset_n            (afu_reset_n),
    .afu_fence              (afu_fence),
    .afu_enable             (afu_enable),
    .ofunc_reset_in_progress(ofunc_reset_in_progress),
    .octrl_reset_in_progress(octrl_reset_in_progress),
    .fence_timeout_err      (fence_timeout_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for afu_reset_n to go low, then counts low cycles up to
  // the first cycle it is high again.
  task automatic wait_low(output int n);
    int guard;
    guard = 0;
    while (afu_reset_n === 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    n = 0;
    while (afu_reset_n === 1'b0 && n < 400) begin
      n++;
      step();
    end
  endtask

  // Steps (bounded) until the fence drops; counts cycles where afu_enable
  // was high while the sequence was still active.
  task automatic wait_idle(output int en_bad);
    int guard;
    guard  = 0;
    en_bad = 0;
    while (afu_fence === 1'b1 && guard < 400) begin
      if (afu_enable !== 1'b0) en_bad++;
      step();
      guard++;
    end
  endtask

  task automatic pulse(input logic func, input logic afu);
    ofunc_func_reset_pulse = func;
    octrl_reset_afu_pulse  = afu;
    step();
    ofunc_func_reset_pulse = 1'b0;
    octrl_reset_afu_pulse  = 1'b0;
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    reset_n                 = 1'b0;
    ofunc_func_reset_pulse  = 1'b0;
    octrl_reset_afu_pulse   = 1'b0;
    octrl_enable_afu        = 1'b0;
    ro_ofunc_reset_duration = 8'h10;
    ro_octrl_reset_duration = 8'h02;
    afu_quiesced            = 1'b1;
    err_clear               = 1'b0;

    // Reset state
    repeat (3) step();
    check_val("rst_afu_reset_n", 32'(afu_reset_n), 32'd0);
    check_val("rst_fence", 32'(afu_fence), 32'd1);
    check_val("rst_enable", 32'(afu_enable), 32'd0);
    check_val("rst_ofunc_bit", 32'(ofunc_reset_in_progress), 32'd1);
    check_val("rst_octrl_bit", 32'(octrl_reset_in_progress), 32'd0);
    check_val("rst_err", 32'(fence_timeout_err), 32'd0);

    // Power-up function reset: 1 + 16*4 low cycles, then settle + DONE
    reset_n = 1'b1;
    wait_low(low_n);
    check_val("pwr_low_cycles", 32'(low_n), 32'd65);
    check_val("pwr_release_fence", 32'(afu_fence), 32'd1);
    repeat (3) step();
    check_val("pwr_ofunc_settle", 32'(ofunc_reset_in_progress), 32'd1);
    step();
    check_val("pwr_ofunc_done", 32'(ofunc_reset_in_progress), 32'd0);
    check_val("pwr_fence_done", 32'(afu_fence), 32'd1);
    step();
    check_val("pwr_idle_fence", 32'(afu_fence), 32'd0);
    check_val("pwr_idle_reset_n", 32'(afu_reset_n), 32'd1);

    // AFU reset, dur=2, quiesced: fence at t1, low t2..t10, bit clears t15
    pulse(1'b0, 1'b1);
    check_val("afu_t1_fence", 32'(afu_fence), 32'd1);
    check_val("afu_t1_reset_n", 32'(afu_reset_n), 32'd1);
    check_val("afu_t1_octrl", 32'(octrl_reset_in_progress), 32'd1);
    check_val("afu_t1_ofunc", 32'(ofunc_reset_in_progress), 32'd0);
    wait_low(low_n);
    check_val("afu_low_cycles", 32'(low_n), 32'd9);
    repeat (3) step();
    check_val("afu_octrl_t14", 32'(octrl_reset_in_progress), 32'd1);
    step();
    check_val("afu_octrl_t15", 32'(octrl_reset_in_progress), 32'd0);
    check_val("afu_ofunc_t15", 32'(ofunc_reset_in_progress), 32'd0);
    step();
    check_val("afu_idle_fence", 32'(afu_fence), 32'd0);

    // Fence timeout: 8 FENCE cycles then error, reset still completes
    afu_quiesced = 1'b0;
    pulse(1'b0, 1'b1);
    repeat (7) step();
    check_val("to_before_err", 32'(fence_timeout_err), 32'd0);
    check_val("to_before_reset_n", 32'(afu_reset_n), 32'd1);
    step();
    check_val("to_err_set", 32'(fence_timeout_err), 32'd1);
    check_val("to_load_reset_n", 32'(afu_reset_n), 32'd0);
    wait_low(low_n);
    check_val("to_low_cycles", 32'(low_n), 32'd9);
    wait_idle(bad_n);
    check_val("to_idle_fence", 32'(afu_fence), 32'd0);
    check_val("to_err_sticky", 32'(fence_timeout_err), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_val("to_err_cleared", 32'(fence_timeout_err), 32'd0);

    // Timeout and err_clear in the same cycle: set wins
    pulse(1'b0, 1'b1);
    repeat (7) step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_val("to_set_wins", 32'(fence_timeout_err), 32'd1);
    wait_idle(bad_n);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_val("to_err_cleared2", 32'(fence_timeout_err), 32'd0);
    afu_quiesced = 1'b1;

    // Func pulse at RESET cycle 3 of an AFU reset: restart with dur=16
    pulse(1'b0, 1'b1);
    repeat (4) step();
    pulse(1'b1, 1'b0);
    check_val("ovl_load_reset_n", 32'(afu_reset_n), 32'd0);
    check_val("ovl_fence", 32'(afu_fence), 32'd1);
    check_val("ovl_ofunc_set", 32'(ofunc_reset_in_progress), 32'd1);
    check_val("ovl_octrl_set", 32'(octrl_reset_in_progress), 32'd1);
    wait_low(low_n);
    check_val("ovl_low_cycles", 32'(low_n), 32'd65);
    repeat (4) step();
    check_val("ovl_ofunc_done", 32'(ofunc_reset_in_progress), 32'd0);
    check_val("ovl_octrl_done", 32'(octrl_reset_in_progress), 32'd0);
    step();
    check_val("ovl_idle_fence", 32'(afu_fence), 32'd0);

    // Both pulses together with zero durations: 1 + 1*4 low cycles
    ro_ofunc_reset_duration = 8'h00;
    ro_octrl_reset_duration = 8'h00;
    pulse(1'b1, 1'b1);
    check_val("both_ofunc_set", 32'(ofunc_reset_in_progress), 32'd1);
    check_val("both_octrl_set", 32'(octrl_reset_in_progress), 32'd1);
    wait_low(low_n);
    check_val("both_low_cycles", 32'(low_n), 32'd5);
    repeat (4) step();
    check_val("both_ofunc_done", 32'(ofunc_reset_in_progress), 32'd0);
    check_val("both_octrl_done", 32'(octrl_reset_in_progress), 32'd0);
    step();
    ro_ofunc_reset_duration = 8'h10;
    ro_octrl_reset_duration = 8'h02;

    // afu_enable follows Enable AFU only while idle
    octrl_enable_afu = 1'b1;
    step();
    check_val("en_idle", 32'(afu_enable), 32'd1);
    pulse(1'b0, 1'b1);
    check_val("en_fence", 32'(afu_enable), 32'd0);
    wait_idle(bad_n);
    check_val("en_active_cycles", 32'(bad_n), 32'd0);
    check_val("en_back_idle", 32'(afu_enable), 32'd1);

    // Asynchronous reset in the middle of RESET
    pulse(1'b0, 1'b1);
    repeat (3) step();
    check_val("ar_pre_reset_n", 32'(afu_reset_n), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("ar_afu_reset_n", 32'(afu_reset_n), 32'd0);
    check_val("ar_fence", 32'(afu_fence), 32'd1);
    check_val("ar_enable", 32'(afu_enable), 32'd0);
    check_val("ar_ofunc", 32'(ofunc_reset_in_progress), 32'd1);
    check_val("ar_octrl", 32'(octrl_reset_in_progress), 32'd0);
    step();
    reset_n = 1'b1;
    wait_low(low_n);
    check_val("ar_low_cycles", 32'(low_n), 32'd65);
    wait_idle(bad_n);
    check_val("ar_final_ofunc", 32'(ofunc_reset_in_progress), 32'd0);
    check_val("ar_final_enable", 32'(afu_enable), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
